// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: interleaves CPU accesses with per-line display prefetch
// into a double-banked line buffer, driven by the raster scan counters.
module vram_scan_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int FETCH_LEN     = 80,
    parameter int LINE_BASE     = 0,
    parameter int H_TRIGGER     = 784,
    parameter int V_FIRST_FETCH = 34,
    parameter int V_LAST_FETCH  = 513
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            h_pos,
    input  logic [9:0]            v_pos,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic                  vram_we,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    input  logic [DATA_WIDTH-1:0] vram_rdata,
    output logic                  lb_we,
    output logic [7:0]            lb_addr,
    output logic [DATA_WIDTH-1:0] lb_wdata,
    output logic                  display_bank,
    output logic                  fetch_overrun
);

    localparam int IDX_W = (FETCH_LEN > 128) ? $clog2(FETCH_LEN) : 7;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    localparam logic [9:0]            H_TRIG   = 10'(H_TRIGGER);
    localparam logic [9:0]            V_FIRST  = 10'(V_FIRST_FETCH);
    localparam logic [9:0]            V_LAST   = 10'(V_LAST_FETCH);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(LINE_BASE);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC = ADDR_WIDTH'(FETCH_LEN);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FETCH_LEN - 1);

    logic [0:0]            state;
    logic [9:0]            h_prev;
    logic [ADDR_WIDTH-1:0] line_ptr;
    logic [IDX_W-1:0]      word_idx;
    logic                  last_cpu;
    logic                  busy;

    // Owner tags travelling alongside each VRAM access.
    logic                  s1_disp, s1_cpu, s1_wr, s1_bank;
    logic [6:0]            s1_idx;
    logic                  s2_cpu, s2_rd;

    logic trig, cpu_pend, grant_cpu, grant_disp;

    assign trig     = (h_pos == H_TRIG) && (h_prev != H_TRIG) &&
                      (v_pos >= V_FIRST) && (v_pos <= V_LAST);
    assign cpu_pend = cpu_req && !busy;

    // The trigger slot itself never issues display, so a coincident CPU request wins it.
    assign grant_cpu  = (trig || state == S_IDLE) ? cpu_pend : (cpu_pend && !last_cpu);
    assign grant_disp = !trig && (state == S_FETCH) && !grant_cpu;

    assign lb_wdata = lb_we ? vram_rdata : '0;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            h_prev        <= '0;
            line_ptr      <= BASE;
            word_idx      <= '0;
            last_cpu      <= 1'b0;
            busy          <= 1'b0;
            display_bank  <= 1'b0;
            fetch_overrun <= 1'b0;
            vram_addr     <= '0;
            vram_we       <= 1'b0;
            vram_wdata    <= '0;
        end else begin
            h_prev  <= h_pos;
            vram_we <= grant_cpu && cpu_wr;
            if (grant_cpu) begin
                vram_addr <= cpu_addr;
                if (cpu_wr) vram_wdata <= cpu_wdata;
            end else if (grant_disp) begin
                vram_addr <= line_ptr + ADDR_WIDTH'(word_idx);
            end

            if (trig) begin
                display_bank <= ~display_bank;
                line_ptr     <= (v_pos == V_FIRST) ? BASE : line_ptr + LINE_INC;
                word_idx     <= '0;
                state        <= S_FETCH;
                last_cpu     <= 1'b1;
                if (state == S_FETCH) fetch_overrun <= 1'b1;
            end else if (grant_disp) begin
                word_idx <= word_idx + 1'b1;
                last_cpu <= 1'b0;
                if (word_idx == LAST_IDX) state <= S_IDLE;
            end else if (grant_cpu) begin
                last_cpu <= 1'b1;
            end

            if (s2_cpu)         busy <= 1'b0;
            else if (grant_cpu) busy <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_disp   <= 1'b0;
            s1_cpu    <= 1'b0;
            s1_wr     <= 1'b0;
            s1_bank   <= 1'b0;
            s1_idx    <= '0;
            s2_cpu    <= 1'b0;
            s2_rd     <= 1'b0;
            lb_we     <= 1'b0;
            lb_addr   <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            s1_disp <= grant_disp;
            s1_cpu  <= grant_cpu;
            s1_wr   <= cpu_wr;
            s1_bank <= ~display_bank;
            s1_idx  <= word_idx[6:0];

            lb_we <= s1_disp;
            if (s1_disp) lb_addr <= {s1_bank, s1_idx};
            s2_cpu <= s1_cpu;
            s2_rd  <= s1_cpu && !s1_wr;

            cpu_ack <= s2_cpu;
            if (s2_rd) cpu_rdata <= vram_rdata;
        end
    end

endmodule
